// File: rtl/img_rom_reader_pkg.sv
// Shared image package: ROM word layout, address width, reader state
// encoding and the 0..255 clamp used when translating points.
package img_rom_reader_pkg;

  // ROM word layout: {last, x[7:0], y[7:0]}
  localparam int IMG_ROM_W    = 17;
  localparam int IMG_LAST_BIT = 16;
  localparam int IMG_X_MSB    = 15;
  localparam int IMG_Y_MSB    = 7;

  // Address width that covers every image start address (highest is 573)
  localparam int IMG_ADR_W    = 10;

  // Width of a screen coordinate
  localparam int IMG_PT_W     = 8;

  // Reader state machine encoding
  typedef enum logic [2:0] {
    RD_IDLE,
    RD_FETCH,
    RD_LOAD,
    RD_SEND,
    RD_DONE
  } img_rd_state_t;

  // Clamp a 10-bit signed intermediate to the visible 0..255 range
  function automatic logic [IMG_PT_W-1:0] img_sat_u8(input logic signed [9:0] v);
    logic [IMG_PT_W-1:0] r;
    if (v < 10'sd0) begin
      r = '0;
    end else if (v > 10'sd255) begin
      r = '1;
    end else begin
      r = v[IMG_PT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/img_rom_reader_translate.sv
// Point translation: pt = clamp(pos + coord - mid) in 10-bit signed
// arithmetic, so both underflow and overflow are visible before clamping.
module img_pt_translate
  import img_rom_reader_pkg::*;
(
  input  logic [IMG_PT_W-1:0] pos,
  input  logic [IMG_PT_W-1:0] coord,
  input  logic [IMG_PT_W-1:0] mid,
  output logic [IMG_PT_W-1:0] pt
);

  logic signed [9:0] sum;

  // Zero-extend all three operands so the sum range -255..510 fits, then clamp
  always_comb begin
    sum = $signed({2'b00, pos}) + $signed({2'b00, coord}) - $signed({2'b00, mid});
    pt  = img_sat_u8(sum);
  end

endmodule

// File: rtl/img_rom_reader.sv
// Vector-image ROM walker: on start, reads points from adr_start onward,
// translates each by (pos - mid) and hands them to the DAC driver over a
// valid/ready handshake until the last flag or the point-count guard.
module img_rom_reader
  import img_rom_reader_pkg::*;
#(
  parameter int ADR_W   = IMG_ADR_W,
  parameter int MAX_PTS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADR_W-1:0]     adr_start,
  input  logic [IMG_PT_W-1:0]  pos_x,
  input  logic [IMG_PT_W-1:0]  pos_y,
  input  logic [IMG_PT_W-1:0]  mid_x,
  input  logic [IMG_PT_W-1:0]  mid_y,
  output logic [ADR_W-1:0]     rom_adr,
  input  logic [IMG_ROM_W-1:0] rom_data,
  output logic [IMG_PT_W-1:0]  pt_x,
  output logic [IMG_PT_W-1:0]  pt_y,
  output logic                 pt_valid,
  input  logic                 pt_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  // Counter is wide enough to hold MAX_PTS itself
  localparam int              CNT_W   = $clog2(MAX_PTS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PTS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [ADR_W-1:0] ADR_ONE = ADR_W'(1);

  img_rd_state_t       state_q, state_d;
  logic [ADR_W-1:0]    rom_adr_q, rom_adr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                last_q, last_d;
  logic [IMG_PT_W-1:0] pt_x_q, pt_x_d;
  logic [IMG_PT_W-1:0] pt_y_q, pt_y_d;
  logic                pt_valid_q, pt_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [IMG_PT_W-1:0] pos_x_q, pos_x_d;
  logic [IMG_PT_W-1:0] pos_y_q, pos_y_d;
  logic [IMG_PT_W-1:0] mid_x_q, mid_x_d;
  logic [IMG_PT_W-1:0] mid_y_q, mid_y_d;
  logic [IMG_PT_W-1:0] tr_x, tr_y;
  logic                xfer;

  // Translation uses the position/midpoint captured at start, never the live inputs
  img_pt_translate u_tr_x (
    .pos   (pos_x_q),
    .coord (rom_data[IMG_X_MSB -: IMG_PT_W]),
    .mid   (mid_x_q),
    .pt    (tr_x)
  );

  img_pt_translate u_tr_y (
    .pos   (pos_y_q),
    .coord (rom_data[IMG_Y_MSB -: IMG_PT_W]),
    .mid   (mid_y_q),
    .pt    (tr_y)
  );

  assign xfer    = pt_valid_q & pt_ready;
  assign cnt_inc = cnt_q + CNT_ONE;

  // Next-state and next-output logic; every register holds unless a state acts on it
  always_comb begin
    state_d    = state_q;
    rom_adr_d  = rom_adr_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    pt_x_d     = pt_x_q;
    pt_y_d     = pt_y_q;
    pt_valid_d = pt_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    mid_x_d    = mid_x_q;
    mid_y_d    = mid_y_q;

    case (state_q)
      RD_IDLE: begin
        if (start) begin
          rom_adr_d = adr_start;
          cnt_d     = '0;
          busy_d    = 1'b1;
          pos_x_d   = pos_x;
          pos_y_d   = pos_y;
          mid_x_d   = mid_x;
          mid_y_d   = mid_y;
          state_d   = RD_FETCH;
        end
      end

      RD_FETCH: begin
        state_d = RD_LOAD;
      end

      RD_LOAD: begin
        pt_x_d     = tr_x;
        pt_y_d     = tr_y;
        last_d     = rom_data[IMG_LAST_BIT];
        pt_valid_d = 1'b1;
        state_d    = RD_SEND;
      end

      RD_SEND: begin
        if (xfer) begin
          pt_valid_d = 1'b0;
          cnt_d      = cnt_inc;
          if (last_q || (cnt_inc == CNT_MAX)) begin
            done_d  = 1'b1;
            err_d   = ~last_q;
            state_d = RD_DONE;
          end else begin
            rom_adr_d = rom_adr_q + ADR_ONE;
            state_d   = RD_FETCH;
          end
        end
      end

      RD_DONE: begin
        busy_d  = 1'b0;
        state_d = RD_IDLE;
      end

      default: begin
        state_d = RD_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately, dropping any pending point
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RD_IDLE;
      rom_adr_q  <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      pt_x_q     <= '0;
      pt_y_q     <= '0;
      pt_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      mid_x_q    <= '0;
      mid_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      rom_adr_q  <= rom_adr_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      pt_x_q     <= pt_x_d;
      pt_y_q     <= pt_y_d;
      pt_valid_q <= pt_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      mid_x_q    <= mid_x_d;
      mid_y_q    <= mid_y_d;
    end
  end

  assign rom_adr  = rom_adr_q;
  assign pt_x     = pt_x_q;
  assign pt_y     = pt_y_q;
  assign pt_valid = pt_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_img_rom_reader.sv
// Bench for img_rom_reader: a synchronous ROM model, a point-list model that
// walks the ROM image by plain arithmetic, and directed image scenarios.
module tb_img_rom_reader;

  localparam int TB_MAX_PTS = 4;
  localparam int ROM_DEPTH  = 1024;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  adr_start;
  logic [7:0]  pos_x, pos_y, mid_x, mid_y;
  logic [9:0]  rom_adr;
  logic [16:0] rom_data;
  logic [7:0]  pt_x, pt_y;
  logic        pt_valid;
  logic        pt_ready;
  logic        busy, done, err;

  logic [16:0] rom [0:ROM_DEPTH-1];

  int check_count = 0;
  int pass_count  = 0;

  // Model state, owned by the compare process
  logic [15:0] exp_q[$];
  bit          exp_err;
  bit          exp_done;
  bit          model_busy;
  bit          hold;
  logic [7:0]  hold_x, hold_y;

  img_rom_reader #(
    .ADR_W   (10),
    .MAX_PTS (TB_MAX_PTS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .adr_start (adr_start),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .mid_x     (mid_x),
    .mid_y     (mid_y),
    .rom_adr   (rom_adr),
    .rom_data  (rom_data),
    .pt_x      (pt_x),
    .pt_y      (pt_y),
    .pt_valid  (pt_valid),
    .pt_ready  (pt_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data for an address appears one cycle later
  always @(posedge clk) rom_data <= rom[rom_adr];

  task automatic checkOutput(input string name, input int act, input int exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int sat8(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // Expected point list for an image: walk until last flag or the point limit
  task automatic buildExpected();
    int          a;
    logic [16:0] w;
    bit          got_last;
    int          ex, ey;
    a = int'(adr_start);
    got_last = 0;
    exp_q.delete();
    for (int i = 0; i < TB_MAX_PTS; i++) begin
      w  = rom[a];
      ex = sat8(int'(pos_x) + int'(w[15:8]) - int'(mid_x));
      ey = sat8(int'(pos_y) + int'(w[7:0]) - int'(mid_y));
      exp_q.push_back({ex[7:0], ey[7:0]});
      if (w[16]) begin
        got_last = 1;
        break;
      end
      a = (a + 1) % ROM_DEPTH;
    end
    exp_err = !got_last;
  endtask

  // Compare process: runs every cycle, away from the active edge
  always @(negedge clk) begin
    bit          accept;
    logic [15:0] e;
    if (rst) begin
      exp_q.delete();
      exp_done   = 0;
      model_busy = 0;
      hold       = 0;
    end else begin
      checkOutput("done", int'(done), int'(exp_done));
      checkOutput("err", int'(err), int'(exp_done & exp_err));
      accept = start && !model_busy;
      if (exp_done) begin
        exp_done   = 0;
        model_busy = 0;
      end
      if (hold) begin
        checkOutput("hold_valid", int'(pt_valid), 1);
        checkOutput("hold_x", int'(pt_x), int'(hold_x));
        checkOutput("hold_y", int'(pt_y), int'(hold_y));
      end
      if (pt_valid && pt_ready) begin
        hold = 0;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_point", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pt_x", int'(pt_x), int'(e[15:8]));
          checkOutput("pt_y", int'(pt_y), int'(e[7:0]));
          if (exp_q.size() == 0) exp_done = 1;
        end
      end else if (pt_valid) begin
        hold   = 1;
        hold_x = pt_x;
        hold_y = pt_y;
      end else begin
        hold = 0;
      end
      if (accept) begin
        buildExpected();
        model_busy = 1;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse with image parameters
  task automatic applyStimulus(input logic [9:0] adr, input logic [7:0] px, input logic [7:0] py,
                               input logic [7:0] mx, input logic [7:0] my);
    start     = 1'b1;
    adr_start = adr;
    pos_x     = px;
    pos_y     = py;
    mid_x     = mx;
    mid_y     = my;
    cycle();
    start     = 1'b0;
  endtask

  task automatic waitValid(input int maxc);
    int n = 0;
    while (!pt_valid && n < maxc) begin
      cycle();
      n++;
    end
    checkOutput("wait_valid", int'(pt_valid), 1);
  endtask

  task automatic waitIdle(input int maxc);
    int n = 0;
    while ((busy || model_busy) && n < maxc) begin
      cycle();
      n++;
    end
    checkOutput("wait_idle_busy", int'(busy), 0);
    checkOutput("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    adr_start = '0;
    pos_x     = '0;
    pos_y     = '0;
    mid_x     = '0;
    mid_y     = '0;
    pt_ready  = 1'b1;
    for (int i = 0; i < ROM_DEPTH; i++) rom[i] = '0;
    rom[517] = {1'b0, 8'd32, 8'd40};
    rom[518] = {1'b1, 8'd40, 8'd40};
    rom[520] = {1'b1, 8'd0,  8'd30};
    for (int i = 0; i < 8; i++) rom[600 + i] = {1'b0, 8'(i * 3 + 1), 8'(i * 5 + 2)};
    rom[573]  = {1'b1, 8'd200, 8'd10};
    rom[1023] = {1'b0, 8'd5, 8'd6};
    rom[0]    = {1'b1, 8'd7, 8'd8};

    // Reset values
    cycle();
    checkOutput("rst_rom_adr", int'(rom_adr), 0);
    checkOutput("rst_pt_valid", int'(pt_valid), 0);
    checkOutput("rst_pt_x", int'(pt_x), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    cycle();
    rst = 1'b0;
    cycle();

    // Cursor image with latency, ignored starts while busy and in the DONE cycle
    $display("[TB] cursor image");
    applyStimulus(10'd517, 8'd100, 8'd100, 8'd32, 8'd40);
    checkOutput("lat_c1_valid", int'(pt_valid), 0);
    checkOutput("lat_c1_busy", int'(busy), 1);
    cycle();
    checkOutput("lat_c2_valid", int'(pt_valid), 0);
    cycle();
    checkOutput("lat_c3_valid", int'(pt_valid), 1);
    checkOutput("cursor_p0_x", int'(pt_x), 100);
    checkOutput("cursor_p0_y", int'(pt_y), 100);
    cycle();
    applyStimulus(10'd600, 8'd1, 8'd2, 8'd3, 8'd4);
    cycle();
    checkOutput("cursor_p1_valid", int'(pt_valid), 1);
    checkOutput("cursor_p1_x", int'(pt_x), 108);
    checkOutput("cursor_p1_y", int'(pt_y), 100);
    cycle();
    checkOutput("cursor_done", int'(done), 1);
    applyStimulus(10'd600, 8'd1, 8'd2, 8'd3, 8'd4);
    checkOutput("after_done_busy", int'(busy), 0);
    cycle();
    cycle();
    checkOutput("ignored_start_valid", int'(pt_valid), 0);
    checkOutput("ignored_start_busy", int'(busy), 0);

    // Saturation both ways
    $display("[TB] saturation");
    applyStimulus(10'd520, 8'd10, 8'd250, 8'd32, 8'd10);
    waitValid(10);
    checkOutput("sat_x", int'(pt_x), 0);
    checkOutput("sat_y", int'(pt_y), 255);
    waitIdle(30);

    // Backpressure holds the point and the address
    $display("[TB] backpressure");
    pt_ready = 1'b0;
    applyStimulus(10'd517, 8'd100, 8'd100, 8'd32, 8'd40);
    waitValid(10);
    checkOutput("bp_rom_adr", int'(rom_adr), 517);
    for (int i = 0; i < 5; i++) begin
      cycle();
      checkOutput("bp_valid", int'(pt_valid), 1);
      checkOutput("bp_adr_hold", int'(rom_adr), 517);
      checkOutput("bp_x", int'(pt_x), 100);
    end
    pt_ready = 1'b1;
    cycle();
    checkOutput("bp_released", int'(pt_valid), 0);
    waitIdle(30);

    // Runaway guard: no last flag, limit reached
    $display("[TB] runaway guard");
    applyStimulus(10'd600, 8'd50, 8'd60, 8'd0, 8'd0);
    waitValid(10);
    checkOutput("run_p0_x", int'(pt_x), 51);
    checkOutput("run_p0_y", int'(pt_y), 62);
    waitIdle(60);

    // Single-point image at the highest start address
    $display("[TB] single point");
    applyStimulus(10'd573, 8'd128, 8'd128, 8'd100, 8'd20);
    waitValid(10);
    checkOutput("single_x", int'(pt_x), 228);
    checkOutput("single_y", int'(pt_y), 118);
    waitIdle(30);

    // Address wrap from 1023 to 0
    $display("[TB] address wrap");
    applyStimulus(10'd1023, 8'd0, 8'd0, 8'd0, 8'd0);
    waitValid(10);
    checkOutput("wrap_adr0", int'(rom_adr), 1023);
    cycle();
    waitValid(10);
    checkOutput("wrap_adr1", int'(rom_adr), 0);
    checkOutput("wrap_x1", int'(pt_x), 7);
    waitIdle(30);

    // Reset in the middle of SEND
    $display("[TB] reset during send");
    pt_ready = 1'b0;
    applyStimulus(10'd517, 8'd100, 8'd100, 8'd32, 8'd40);
    waitValid(10);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", int'(pt_valid), 0);
    checkOutput("mid_rst_x", int'(pt_x), 0);
    checkOutput("mid_rst_adr", int'(rom_adr), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_done", int'(done), 0);
    cycle();
    rst      = 1'b0;
    pt_ready = 1'b1;
    cycle();
    applyStimulus(10'd517, 8'd100, 8'd100, 8'd32, 8'd40);
    waitValid(10);
    checkOutput("redraw_x", int'(pt_x), 100);
    checkOutput("redraw_adr", int'(rom_adr), 517);
    waitIdle(30);

    cycle();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
